// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes on both sides and an iterative 1-bit/cycle shifter.
// Define BARREL_SHIFT_EN to replace the iterative shifter with a combinational barrel shifter (latency 1 for all ops).
module alu_exec_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DONE  = 2'd1;
`ifndef BARREL_SHIFT_EN
   localparam logic [1:0] S_SHIFT = 2'd2;
`endif

   logic [1:0]         r_state;
   logic [XLEN-1:0]    r_result;
   logic               r_zero;
   logic               r_illegal;
   logic [XLEN-1:0]    w_alu;
   logic               w_illegal;
   logic [SHAMT_W-1:0] w_shamt;
`ifndef BARREL_SHIFT_EN
   logic               w_is_shift;
   logic [3:0]         r_op;
   logic [SHAMT_W-1:0] r_cnt;
   logic [XLEN-1:0]    w_step;
`endif

   assign w_shamt = b[SHAMT_W-1:0];

   always_comb begin
      w_alu     = '0;
      w_illegal = 1'b0;
`ifndef BARREL_SHIFT_EN
      w_is_shift = 1'b0;
`endif
      case (alu_control)
         ALU_ADD:  w_alu = a + b;
         ALU_SUB:  w_alu = a - b;
         ALU_AND:  w_alu = a & b;
         ALU_OR:   w_alu = a | b;
         ALU_XOR:  w_alu = a ^ b;
         ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef BARREL_SHIFT_EN
         ALU_SLL:  w_alu = a << w_shamt;
         ALU_SRL:  w_alu = a >> w_shamt;
         ALU_SRA:  w_alu = $unsigned($signed(a) >>> w_shamt);
`else
         // a is the zero-shamt result; nonzero shamt starts the iterative path
         ALU_SLL, ALU_SRL, ALU_SRA: begin
            w_alu      = a;
            w_is_shift = 1'b1;
         end
`endif
         default:  w_illegal = 1'b1;
      endcase
   end

`ifndef BARREL_SHIFT_EN
   always_comb begin
      case (r_op)
         ALU_SLL: w_step = {r_result[XLEN-2:0], 1'b0};
         ALU_SRL: w_step = {1'b0, r_result[XLEN-1:1]};
         default: w_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
      endcase
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
`ifndef BARREL_SHIFT_EN
         r_op      <= '0;
         r_cnt     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_illegal <= w_illegal;
`ifndef BARREL_SHIFT_EN
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_result <= a;
                     r_zero   <= 1'b0;
                     r_op     <= alu_control;
                     r_cnt    <= w_shamt;
                     r_state  <= S_SHIFT;
                  end else
`endif
                  begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == '0);
                     r_state  <= S_DONE;
                  end
               end
            end
`ifndef BARREL_SHIFT_EN
            S_SHIFT: begin
               r_result <= w_step;
               r_cnt    <= r_cnt - SHAMT_W'(1);
               if (r_cnt == SHAMT_W'(1)) begin
                  r_zero  <= (w_step == '0);
                  r_state <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: handshake timing, arithmetic/logic/compare, shifts, backpressure, reset.
module tb_alu_exec_unit;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_control = 4'h0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish in time");
      $fatal(1);
   end

   // Drives one request, scrambles inputs after the accept edge, and waits (bounded) for out_valid.
   // cyc counts rising edges after the accept edge until out_valid is seen.
   task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int cyc, output logic [31:0] res, output logic z,
                         output logic ill, output logic rdy);
      @(negedge clk);
      rdy = in_ready;
      in_valid = 1'b1; alu_control = op; a = av; b = bv;
      @(posedge clk); #1;
      in_valid = 1'b0; alu_control = 4'h0; a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      res = result; z = zero; ill = illegal;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      #2;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_hold in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid); end
      checks++; if (result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin errors++;
         $display("FAIL reset_hold_out result=%h zero=%b illegal=%b expected 0/0/0", result, zero, illegal); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
      run_op(OP_ADD, 32'd7, 32'd9, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'd16 || out_valid !== 1'b1) begin errors++;
         $display("FAIL pre_async_add result=%h out_valid=%b expected 00000010/1", res, out_valid); end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin errors++;
         $display("FAIL async_reset out_valid=%b result=%h in_ready=%b expected 0/0/0", out_valid, result, in_ready); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL async_reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
   endtask

   task automatic test_add_sub();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, cyc, res, z, ill, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready in_ready=%b expected 1", rdy); end
      checks++; if (cyc !== 0) begin errors++; $display("FAIL add_latency edges=%0d expected 0", cyc); end
      checks++; if (res !== 32'h0 || z !== 1'b1 || ill !== 1'b0) begin errors++;
         $display("FAIL add_wrap result=%h zero=%b illegal=%b expected 00000000/1/0", res, z, ill); end
      release_out();
      run_op(OP_SUB, 32'd5, 32'd7, cyc, res, z, ill, rdy);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL sub_latency edges=%0d expected 0", cyc); end
      checks++; if (res !== 32'hFFFF_FFFE || z !== 1'b0) begin errors++;
         $display("FAIL sub_wrap result=%h zero=%b expected fffffffe/0", res, z); end
      release_out();
   endtask

   task automatic test_logic();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(OP_AND, 32'hF0F0_1234, 32'hFF00_00FF, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'hF000_0034) begin errors++; $display("FAIL and result=%h expected f0000034", res); end
      release_out();
      run_op(OP_OR, 32'hF0F0_1234, 32'hFF00_00FF, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'hFFF0_12FF) begin errors++; $display("FAIL or result=%h expected fff012ff", res); end
      release_out();
      run_op(OP_XOR, 32'hF0F0_1234, 32'hFF00_00FF, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h0FF0_12CB) begin errors++; $display("FAIL xor result=%h expected 0ff012cb", res); end
      release_out();
   endtask

   task automatic test_compare();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h1 || z !== 1'b0) begin errors++;
         $display("FAIL slt_neg result=%h zero=%b expected 00000001/0", res, z); end
      release_out();
      run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h0 || z !== 1'b1) begin errors++;
         $display("FAIL sltu result=%h zero=%b expected 00000000/1", res, z); end
      release_out();
      run_op(OP_SLT, 32'h1, 32'hFFFF_FFFF, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL slt_pos result=%h expected 00000000", res); end
      release_out();
   endtask

   task automatic test_shift();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(OP_SRA, 32'h8000_0000, 32'h0000_003F, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31 result=%h expected ffffffff", res); end
      checks++; if (cyc !== (BARREL ? 0 : 31)) begin errors++;
         $display("FAIL sra31_latency edges=%0d expected %0d", cyc, (BARREL ? 0 : 31)); end
      release_out();
      run_op(OP_SLL, 32'h1, 32'h4, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h10 || cyc !== (BARREL ? 0 : 4)) begin errors++;
         $display("FAIL sll4 result=%h edges=%0d expected 00000010/%0d", res, cyc, (BARREL ? 0 : 4)); end
      release_out();
      run_op(OP_SRL, 32'h80, 32'h0, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h80 || cyc !== 0) begin errors++;
         $display("FAIL srl0 result=%h edges=%0d expected 00000080/0", res, cyc); end
      release_out();
      run_op(OP_SRL, 32'h80, 32'hFFFF_FFE1, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h40 || cyc !== (BARREL ? 0 : 1)) begin errors++;
         $display("FAIL srl_upper_b result=%h edges=%0d expected 00000040/%0d", res, cyc, (BARREL ? 0 : 1)); end
      release_out();
      run_op(OP_SLL, 32'h8000_0000, 32'h1, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h0 || z !== 1'b1) begin errors++;
         $display("FAIL sll_out result=%h zero=%b expected 00000000/1", res, z); end
      release_out();
      run_op(OP_SRA, 32'h7000_0000, 32'h4, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'h0700_0000 || z !== 1'b0) begin errors++;
         $display("FAIL sra_pos result=%h zero=%b expected 07000000/0", res, z); end
      release_out();
   endtask

   task automatic test_backpressure();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(OP_ADD, 32'h10, 32'h20, cyc, res, z, ill, rdy);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; alu_control = OP_SUB; a = 32'd1; b = 32'd1;
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_hold_%0d out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
         checks++; if (result !== 32'h30 || zero !== 1'b0 || illegal !== 1'b0) begin errors++;
            $display("FAIL bp_stable_%0d result=%h zero=%b illegal=%b expected 00000030/0/0", i, result, zero, illegal); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_no_reaccept out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid_shift();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      logic seen;
      @(negedge clk);
      in_valid = 1'b1; alu_control = OP_SRL; a = 32'hFFFF_0000; b = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || result !== 32'h0) begin errors++;
         $display("FAIL mid_shift_reset out_valid=%b result=%h expected 0/00000000", out_valid, result); end
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL mid_shift_abort out_valid_seen=%b in_ready=%b expected 0/1", seen, in_ready); end
      run_op(OP_ADD, 32'd2, 32'd3, cyc, res, z, ill, rdy);
      checks++; if (res !== 32'd5 || cyc !== 0 || rdy !== 1'b1) begin errors++;
         $display("FAIL post_reset_add result=%h edges=%0d ready=%b expected 00000005/0/1", res, cyc, rdy); end
      release_out();
   endtask

   task automatic test_illegal();
      int cyc; logic [31:0] res; logic z, ill, rdy;
      run_op(4'hF, 32'h1234_5678, 32'h1, cyc, res, z, ill, rdy);
      checks++; if (ill !== 1'b1 || res !== 32'h0 || z !== 1'b1 || cyc !== 0) begin errors++;
         $display("FAIL illegal_f illegal=%b result=%h zero=%b edges=%0d expected 1/00000000/1/0", ill, res, z, cyc); end
      release_out();
      run_op(4'hA, 32'hFFFF_FFFF, 32'h3, cyc, res, z, ill, rdy);
      checks++; if (ill !== 1'b1 || res !== 32'h0) begin errors++;
         $display("FAIL illegal_a illegal=%b result=%h expected 1/00000000", ill, res); end
      release_out();
      run_op(OP_XOR, 32'h1, 32'h3, cyc, res, z, ill, rdy);
      checks++; if (ill !== 1'b0 || res !== 32'h2) begin errors++;
         $display("FAIL illegal_clear illegal=%b result=%h expected 0/00000002", ill, res); end
      release_out();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_compare();
      test_shift();
      test_backpressure();
      test_reset_mid_shift();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
